// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus request/response types and AXI-style burst encodings.
package cbus_mem_responder_pkg;

    typedef logic [7:0] mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        logic [2:0]      size;
        logic [31:0]     addr;
        logic [3:0]      strobe;
        logic [31:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts of 32-bit beats.
module cbus_burst_addr_gen
    import cbus_mem_responder_pkg::*;
(
    input  logic [31:0]     cur_addr_i,
    input  mlen_t           len_i,
    input  axi_burst_type_t burst_i,
    output logic [31:0]     next_addr_o
);

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic        wrap_ok;

    always_comb begin
        incr_addr = cur_addr_i + 32'd4;
        // Byte-offset mask of the (len+1)*4-byte wrap block; only meaningful for 2/4/8/16 beats.
        wrap_mask = {22'd0, len_i, 2'b11};
        wrap_ok   = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);

        unique case (burst_i)
            BURST_FIXED: next_addr_o = cur_addr_i;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_addr_o = (cur_addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
                end else begin
                    next_addr_o = incr_addr;
                end
            end
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus memory responder: word-addressed array serving single and burst accesses
// after a fixed first-beat latency.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int unsigned LatW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d, next_addr;
    mlen_t                 len_q, len_d, beat_q, beat_d;
    axi_burst_type_t       burst_q, burst_d;
    logic                  is_write_q, is_write_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic [DEPTH_LOG2-1:0] index;
    logic                  beat_fire;
    logic                  last_beat;
    logic                  unused_size;

    logic [31:0] mem_q [2**DEPTH_LOG2];

    assign index       = addr_q[DEPTH_LOG2+1:2];
    assign last_beat   = (beat_q == len_q);
    // An initiator dropping valid mid-transaction suppresses the beat in that same cycle.
    assign beat_fire   = (state_q == StBurst) && creq.valid;
    assign unused_size = ^creq.size;

    cbus_burst_addr_gen u_addr_gen (
        .cur_addr_i  (addr_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            burst_q    <= BURST_FIXED;
            is_write_q <= 1'b0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            burst_q    <= burst_d;
            is_write_q <= is_write_d;
            lat_q      <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (creq.valid) state_d = (LATENCY == 0) ? StBurst : StWait;
            end
            StWait: begin
                if (!creq.valid)              state_d = StIdle;
                else if (lat_q <= LatW'(1))   state_d = StBurst;
            end
            StBurst: begin
                if (!creq.valid || last_beat) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        burst_d    = burst_q;
        is_write_d = is_write_q;
        lat_d      = lat_q;
        if (state_q == StIdle && creq.valid) begin
            addr_d     = creq.addr;
            len_d      = creq.len;
            burst_d    = creq.burst;
            is_write_d = creq.is_write;
            beat_d     = '0;
            lat_d      = LatW'(LATENCY);
        end else if (state_q == StWait && creq.valid) begin
            lat_d = lat_q - LatW'(1);
        end else if (beat_fire) begin
            addr_d = next_addr;
            beat_d = beat_q + 8'd1;
        end
    end

    always_comb begin
        cresp       = '0;
        cresp.ready = beat_fire;
        cresp.last  = (state_q == StBurst) && last_beat;
        if (state_q == StBurst && !is_write_q) cresp.data = mem_q[index];
    end

    // Storage is deliberately unreset; contents are preloaded by the environment.
    always_ff @(posedge clk) begin
        if (beat_fire && is_write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) mem_q[index][8*i +: 8] <= creq.data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Self-checking bench: three responders (latency 0/1/3) against a behavioural memory model.
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam int Words = 4096;

    logic       clk;
    logic       resetn;
    cbus_req_t  req  [3];
    cbus_resp_t resp [3];

    logic [31:0] mdl [3][Words];
    logic [31:0] wdat [32];
    logic [3:0]  wstb [32];
    logic [31:0] rd_obs [32];

    int errors = 0;
    int checks = 0;

    cbus_mem_responder #(.DEPTH_LOG2(12), .LATENCY(0)) u_lat0 (
        .clk(clk), .resetn(resetn), .creq(req[0]), .cresp(resp[0]));
    cbus_mem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .creq(req[1]), .cresp(resp[1]));
    cbus_mem_responder #(.DEPTH_LOG2(12), .LATENCY(3)) u_lat3 (
        .clk(clk), .resetn(resetn), .creq(req[2]), .cresp(resp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic poke(input int d, input int i, input logic [31:0] v);
        mdl[d][i] = v;
        case (d)
            0:       u_lat0.mem_q[i] <= v;
            1:       u_lat1.mem_q[i] <= v;
            default: u_lat3.mem_q[i] <= v;
        endcase
    endtask

    // Byte address of beat k, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input axi_burst_type_t b, input int k);
        int unsigned n, blk, off;
        n = len + 1;
        if (b == BURST_FIXED) return a;
        if (b == BURST_WRAP && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            blk = n * 4;
            off = a % blk;
            return (a - off) + ((off + 4 * k) % blk);
        end
        return a + 32'(4 * k);
    endfunction

    task automatic txn(input int d, input bit wr, input logic [31:0] a, input int len,
                       input axi_burst_type_t b, input int abort_at, input bit hold);
        int lat, idx;
        bit aborted;
        logic [31:0] m;
        lat = lat_of(d);
        aborted = 0;
        @(negedge clk);
        req[d]          = '0;
        req[d].valid    = 1'b1;
        req[d].is_write = wr;
        req[d].size     = 3'd2;
        req[d].addr     = a;
        req[d].len      = mlen_t'(len);
        req[d].burst    = b;
        #1 chk("idle_ready", 32'(resp[d].ready), 0);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            #1 chk("wait_ready", 32'(resp[d].ready), 0);
            chk("wait_data", resp[d].data, 0);
        end
        for (int k = 0; k <= len && !aborted; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                req[d].valid = 1'b0;
                #1 chk("abort_ready", 32'(resp[d].ready), 0);
                aborted = 1;
            end else begin
                if (wr) begin
                    req[d].data   = wdat[k];
                    req[d].strobe = wstb[k];
                end
                #1;
                chk("beat_ready", 32'(resp[d].ready), 1);
                chk("beat_last", 32'(resp[d].last), 32'(k == len));
                idx = int'((beat_addr(a, len, b, k) >> 2) % Words);
                if (wr) begin
                    chk("wr_data_zero", resp[d].data, 0);
                    m = {{8{wstb[k][3]}}, {8{wstb[k][2]}}, {8{wstb[k][1]}}, {8{wstb[k][0]}}};
                    mdl[d][idx] = (mdl[d][idx] & ~m) | (wdat[k] & m);
                end else begin
                    chk("rd_data", resp[d].data, mdl[d][idx]);
                    rd_obs[k] = resp[d].data;
                end
            end
        end
        if (aborted || !hold) begin
            @(negedge clk);
            req[d].valid = 1'b0;
            #1 chk("post_ready", 32'(resp[d].ready), 0);
            chk("post_last", 32'(resp[d].last), 0);
        end
    endtask

    // Single read; counts cycles from the request cycle to the first ready.
    task automatic measure(input int d, input logic [31:0] a, output int n,
                           output logic [31:0] dat, output logic lst);
        n = -1;
        dat = '0;
        lst = 1'b0;
        @(negedge clk);
        req[d]       = '0;
        req[d].valid = 1'b1;
        req[d].addr  = a;
        req[d].burst = BURST_INCR;
        for (int c = 1; c <= 10 && n < 0; c++) begin
            @(negedge clk);
            #1;
            if (resp[d].ready) begin
                n = c;
                dat = resp[d].data;
                lst = resp[d].last;
            end
        end
        @(negedge clk);
        req[d].valid = 1'b0;
        #1 chk("measure_post_ready", 32'(resp[d].ready), 0);
    endtask

    initial begin
        int n, len, ab, sel;
        bit wr, hold;
        logic [31:0] dat, a;
        logic lst;
        axi_burst_type_t b;

        resetn = 1'b0;
        for (int d = 0; d < 3; d++) req[d] = '0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < Words; i++) poke(d, i, $urandom);
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 32'(resp[d].ready), 0);
            chk("reset_last", 32'(resp[d].last), 0);
            chk("reset_data", resp[d].data, 0);
        end
        resetn = 1'b1;

        // Single read on each latency variant.
        for (int d = 0; d < 3; d++) poke(d, 4, 32'hDEADBEEF);
        measure(1, 32'h10, n, dat, lst);
        chk("lat1_first_ready", 32'(n), 2);
        chk("lat1_data", dat, 32'hDEADBEEF);
        chk("lat1_last", 32'(lst), 1);
        measure(0, 32'h10, n, dat, lst);
        chk("lat0_first_ready", 32'(n), 1);
        chk("lat0_data", dat, 32'hDEADBEEF);
        measure(2, 32'h10, n, dat, lst);
        chk("lat3_first_ready", 32'(n), 4);
        chk("lat3_data", dat, 32'hDEADBEEF);

        // INCR write with a narrow beat, then readback.
        for (int i = 0; i < 4; i++) poke(1, 32'h40 + i, 32'hAAAAAAAA);
        wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
        wdat[2] = 32'h33333333; wdat[3] = 32'h44444444;
        wstb[0] = 4'hF; wstb[1] = 4'hF; wstb[2] = 4'h3; wstb[3] = 4'hF;
        txn(1, 1'b1, 32'h100, 3, BURST_INCR, -1, 1'b0);
        txn(1, 1'b0, 32'h100, 3, BURST_INCR, -1, 1'b0);
        chk("incr_rb0", rd_obs[0], 32'h11111111);
        chk("incr_rb1", rd_obs[1], 32'h22222222);
        chk("incr_rb2", rd_obs[2], 32'hAAAA3333);
        chk("incr_rb3", rd_obs[3], 32'h44444444);

        // WRAP read starting mid-block.
        for (int i = 0; i < 4; i++) poke(1, 32'h80 + i, 32'(i));
        txn(1, 1'b0, 32'h208, 3, BURST_WRAP, -1, 1'b0);
        chk("wrap0", rd_obs[0], 2);
        chk("wrap1", rd_obs[1], 3);
        chk("wrap2", rd_obs[2], 0);
        chk("wrap3", rd_obs[3], 1);

        // Back-to-back with valid held through the last beat.
        for (int d = 0; d < 3; d++) begin
            txn(d, 1'b0, 32'h10, 1, BURST_INCR, -1, 1'b1);
            txn(d, 1'b0, 32'h100, 0, BURST_INCR, -1, 1'b0);
        end

        // Abort an 8-beat write after two beats.
        for (int i = 0; i < 8; i++) begin
            poke(1, 32'h100 + i, 32'h5A5A5A5A);
            wdat[i] = $urandom;
            wstb[i] = 4'hF;
        end
        txn(1, 1'b1, 32'h400, 7, BURST_INCR, 2, 1'b0);
        txn(1, 1'b0, 32'h400, 7, BURST_INCR, -1, 1'b0);
        chk("abort_rb0", rd_obs[0], wdat[0]);
        chk("abort_rb1", rd_obs[1], wdat[1]);
        for (int i = 2; i < 8; i++) chk("abort_rb_untouched", rd_obs[i], 32'h5A5A5A5A);

        // Asynchronous reset during beat 2 of a read.
        @(negedge clk);
        req[1]       = '0;
        req[1].valid = 1'b1;
        req[1].addr  = 32'h300;
        req[1].len   = 8'd3;
        req[1].burst = BURST_INCR;
        repeat (4) @(negedge clk);
        #1 chk("pre_reset_ready", 32'(resp[1].ready), 1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_ready", 32'(resp[1].ready), 0);
        chk("arst_last", 32'(resp[1].last), 0);
        chk("arst_data", resp[1].data, 0);
        req[1] = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        txn(1, 1'b0, 32'h300, 3, BURST_INCR, -1, 1'b0);

        // Randomised traffic against the model.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 40; t++) begin
                wr  = 1'($urandom_range(0, 1));
                b   = axi_burst_type_t'(2'($urandom_range(0, 2)));
                sel = $urandom_range(0, 6);
                len = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 3 :
                      (sel == 3) ? 7 : (sel == 4) ? 15 : $urandom_range(0, 20);
                a   = $urandom;
                if ($urandom_range(0, 1) == 0) a = a & 32'h0000_03FF;
                ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                hold = (t != 39) && (ab < 0) && ($urandom_range(0, 3) == 0);
                for (int k = 0; k <= len; k++) begin
                    wdat[k] = $urandom;
                    wstb[k] = 4'($urandom_range(0, 15));
                end
                txn(d, wr, a, len, b, ab, hold);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
